pixel_stream_tx: RTL and testbench

- Raster-scan pixel transmitter. Drives the pixel-in stream (10-bit pixel plus `control` qualifier) consumed by the Sobel filter and other window filters.
- Pulls pixels from an upstream valid/ready source, typically a frame-buffer reader, through a small FIFO.
- Emits each frame as SIZE_Y lines of SIZE_X active pixels, with `control`=1 for active pixels and `control`=0 during horizontal and vertical blanking.
- Flags underflow without ever breaking the raster geometry.

---
 rtl/video_pkg.sv | 15 +
 rtl/pix_fifo.sv | 50 +++++
 rtl/pixel_stream_tx.sv | 207 ++++++++++++++++++++
 tb/tb_pixel_stream_tx.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared pixel width, default raster size, tx state encoding
package video_pkg;

  localparam int PIX_W      = 10;
  localparam int DEF_SIZE_X = 800;
  localparam int DEF_SIZE_Y = 600;

  typedef enum logic [1:0] {IDLE, ACTIVE, HBLANK, VBLANK} tx_state_t;

  // Counter width for a bound of n states; never collapses to zero bits.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// rtl/pix_fifo.sv - synchronous show-ahead FIFO, power-of-2 depth
module pix_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  // One extra pointer bit distinguishes full from empty.
  logic [AW:0]      wr_q, wr_d, rd_q, rd_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign empty   = (wr_q == rd_q);
  assign full    = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign dout    = mem_q[rd_q[AW-1:0]];

  always_comb begin
    wr_d = wr_q;
    rd_d = rd_q;
    if (do_push) wr_d = wr_q + 1'b1;
    if (do_pop)  rd_d = rd_q + 1'b1;
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      wr_q <= '0;
      rd_q <= '0;
    end else begin
      wr_q <= wr_d;
      rd_q <= rd_d;
    end
  end

  always_ff @(posedge clock) begin
    if (do_push) mem_q[wr_q[AW-1:0]] <= din;
  end

endmodule

// File: rtl/pixel_stream_tx.sv
// rtl/pixel_stream_tx.sv - raster pixel transmitter with blanking and underflow flag
// TEST_PATTERN_EN adds pattern_sel to replace FIFO pixels with an x^y test pattern.
module pixel_stream_tx
  import video_pkg::*;
#(
  parameter int SIZE_X     = DEF_SIZE_X,
  parameter int SIZE_Y     = DEF_SIZE_Y,
  parameter int HBLANK     = 16,
  parameter int VBLANK     = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             enable,
`ifdef TEST_PATTERN_EN
  input  logic             pattern_sel,
`endif
  input  logic [PIX_W-1:0] s_pix,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [PIX_W-1:0] pix_out,
  output logic             control,
  output logic             sof,
  output logic             eol,
  output logic             underflow,
  output logic             busy
);

  localparam int XW   = cnt_w(SIZE_X);
  localparam int YW   = cnt_w(SIZE_Y);
  localparam int HW   = cnt_w(HBLANK);
  localparam int VLEN = VBLANK * (SIZE_X + HBLANK);
  localparam int VW   = cnt_w(VLEN);

  localparam logic [XW-1:0] X_LAST = XW'(SIZE_X - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(SIZE_Y - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HBLANK - 1);
  localparam logic [VW-1:0] V_LAST = VW'(VLEN - 1);

  tx_state_t        state_q, state_d;
  logic [XW-1:0]    x_q, x_d;
  logic [YW-1:0]    y_q, y_d;
  logic [HW-1:0]    h_q, h_d;
  logic [VW-1:0]    v_q, v_d;
  logic [PIX_W-1:0] pix_q, pix_d;
  logic             control_q, control_d;
  logic             sof_q, sof_d;
  logic             eol_q, eol_d;
  logic             underflow_q, underflow_d;
  logic             busy_q, busy_d;

  logic             pop, push, fifo_full, fifo_empty;
  logic [PIX_W-1:0] fifo_dout;
  logic             pat_on, start_ok;
  logic [PIX_W-1:0] pat_pix;

  assign s_ready = reset_n && !fifo_full;
  assign push    = s_valid && s_ready;

  pix_fifo #(.WIDTH(PIX_W), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (s_pix),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

`ifdef TEST_PATTERN_EN
  logic pat_q, pat_d;
  assign pat_on   = pat_q;
  assign pat_pix  = {8'(x_q) ^ 8'(y_q), 2'b00};
  assign start_ok = enable;
`else
  assign pat_on   = 1'b0;
  assign pat_pix  = '0;
  assign start_ok = enable && !fifo_empty;
`endif

  always_comb begin : next_state_logic
    logic start_frame;
    logic frame_done;
    start_frame = 1'b0;
    frame_done  = 1'b0;
    state_d     = state_q;
    x_d         = x_q;
    y_d         = y_q;
    h_d         = h_q;
    v_d         = v_q;
    pix_d       = '0;
    control_d   = 1'b0;
    sof_d       = 1'b0;
    eol_d       = 1'b0;
    underflow_d = underflow_q;
    pop         = 1'b0;
`ifdef TEST_PATTERN_EN
    pat_d       = pat_q;
`endif
    case (state_q)
      video_pkg::IDLE: begin
        if (start_ok) begin
          start_frame = 1'b1;
          underflow_d = 1'b0;
        end
      end
      video_pkg::ACTIVE: begin
        control_d = 1'b1;
        sof_d     = (x_q == '0) && (y_q == '0);
        eol_d     = (x_q == X_LAST);
        if (pat_on) begin
          pix_d = pat_pix;
        end else if (!fifo_empty) begin
          pop   = 1'b1;
          pix_d = fifo_dout;
        end else begin
          // Keep counting through an empty FIFO so downstream windows stay aligned.
          underflow_d = 1'b1;
        end
        if (x_q == X_LAST) begin
          x_d     = '0;
          h_d     = '0;
          state_d = video_pkg::HBLANK;
        end else begin
          x_d = x_q + 1'b1;
        end
      end
      video_pkg::HBLANK: begin
        if (h_q == H_LAST) begin
          if (y_q != Y_LAST) begin
            y_d     = y_q + 1'b1;
            state_d = video_pkg::ACTIVE;
          end else if (VBLANK > 0) begin
            v_d     = '0;
            state_d = video_pkg::VBLANK;
          end else begin
            frame_done = 1'b1;
          end
        end else begin
          h_d = h_q + 1'b1;
        end
      end
      video_pkg::VBLANK: begin
        if (v_q == V_LAST) frame_done = 1'b1;
        else               v_d = v_q + 1'b1;
      end
      default: state_d = video_pkg::IDLE;
    endcase

    if (frame_done) begin
      if (enable) start_frame = 1'b1;
      else        state_d = video_pkg::IDLE;
    end
    if (start_frame) begin
      state_d = video_pkg::ACTIVE;
      x_d     = '0;
      y_d     = '0;
`ifdef TEST_PATTERN_EN
      pat_d   = pattern_sel;
`endif
    end
    busy_d = (state_d != video_pkg::IDLE);
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q     <= video_pkg::IDLE;
      x_q         <= '0;
      y_q         <= '0;
      h_q         <= '0;
      v_q         <= '0;
      pix_q       <= '0;
      control_q   <= 1'b0;
      sof_q       <= 1'b0;
      eol_q       <= 1'b0;
      underflow_q <= 1'b0;
      busy_q      <= 1'b0;
`ifdef TEST_PATTERN_EN
      pat_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      h_q         <= h_d;
      v_q         <= v_d;
      pix_q       <= pix_d;
      control_q   <= control_d;
      sof_q       <= sof_d;
      eol_q       <= eol_d;
      underflow_q <= underflow_d;
      busy_q      <= busy_d;
`ifdef TEST_PATTERN_EN
      pat_q       <= pat_d;
`endif
    end
  end

  assign pix_out   = pix_q;
  assign control   = control_q;
  assign sof       = sof_q;
  assign eol       = eol_q;
  assign underflow = underflow_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_pixel_stream_tx.sv
// tb/tb_pixel_stream_tx.sv - scoreboard bench for pixel_stream_tx (4x2 raster, HBLANK 2, VBLANK 1)
module tb_pixel_stream_tx;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       enable;
  logic [9:0] s_pix;
  logic       s_valid;
  logic       s_ready;
  logic [9:0] pix_out;
  logic       control, sof, eol, underflow, busy;
`ifdef TEST_PATTERN_EN
  logic       pattern_sel = 1'b0;
`endif

  always #5 clock = ~clock;

  pixel_stream_tx #(
    .SIZE_X(4), .SIZE_Y(2), .HBLANK(2), .VBLANK(1), .FIFO_DEPTH(4)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .enable    (enable),
`ifdef TEST_PATTERN_EN
    .pattern_sel (pattern_sel),
`endif
    .s_pix     (s_pix),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .pix_out   (pix_out),
    .control   (control),
    .sof       (sof),
    .eol       (eol),
    .underflow (underflow),
    .busy      (busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Shared between the stimulus/monitor process and the test sequence.
  logic [9:0] exp_q[$];
  int  src_total = 0, n_src = 0, n_acc = 0;
  int  frames_left = 0, ph = -1;
  bit  done = 0, abort_req = 0, quiet = 0, pat_mode = 0, uf_exp = 0;
  int  quiet_viol = 0, sof_stray = 0;
  bit  pending = 0;
  logic [9:0] pend_pix;
  int  m_line, m_col;
  bit  e_ctrl;
  logic [9:0] e_pix;

  // Source driver plus output scoreboard; acts 1 time unit after each falling edge.
  initial begin : src_and_mon
    s_valid = 1'b0;
    s_pix   = '0;
    forever begin
      @(negedge clock);
      #1;
      if (abort_req) begin
        exp_q.delete();
        pending   = 0;
        ph        = -1;
        uf_exp    = 0;
        abort_req = 0;
      end else begin
        if (ph < 0 && frames_left > 0 && control === 1'b1 && sof === 1'b1) begin
          ph     = 0;
          uf_exp = 0;
        end
        if (ph >= 0) begin
          m_line = ph / 6;
          m_col  = ph % 6;
          e_ctrl = (m_line < 2) && (m_col < 4);
          e_pix  = '0;
          if (e_ctrl) begin
            if (pat_mode)              e_pix = {8'(m_col ^ m_line), 2'b00};
            else if (exp_q.size() > 0) e_pix = exp_q.pop_front();
            else                       uf_exp = 1;
          end
          check_val("control", control, e_ctrl);
          check_val("sof", sof, ph == 0);
          check_val("eol", eol, e_ctrl && m_col == 3);
          check_val("pix_out", pix_out, e_pix);
          check_val("underflow", underflow, uf_exp);
          if (ph < 16) check_val("busy", busy, 1);
          ph++;
          if (ph == 18) begin
            frames_left--;
            ph = (frames_left > 0) ? 0 : -1;
            if (frames_left == 0) done = 1;
          end
        end else begin
          if (quiet && (control || sof || eol || busy || pix_out != 0)) quiet_viol++;
          if (sof) sof_stray++;
        end
        if (pending) begin
          exp_q.push_back(pend_pix);
          n_acc++;
        end
        pending = 0;
      end
      if (n_src < src_total) begin
        s_valid = 1'b1;
        s_pix   = 10'(n_src + 1);
      end else begin
        s_valid = 1'b0;
      end
      #1;
      if (s_valid && s_ready) begin
        pending  = 1;
        pend_pix = s_pix;
        n_src++;
      end
    end
  end

  // mode 0: ph>=arg, 1: done, 2: frames_left<=arg, 3: busy low
  task automatic wait_for(input int mode, input int arg, input string tag);
    bit hit = 0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      case (mode)
        0:       hit = (ph >= arg);
        1:       hit = done;
        2:       hit = (frames_left <= arg);
        default: hit = (busy == 1'b0);
      endcase
      if (hit) break;
    end
    if (!hit) check_val(tag, 0, 1);
  endtask

  task automatic do_reset();
    frames_left = 0;
    done        = 0;
    @(negedge clock);
    reset_n   = 1'b0;
    abort_req = 1;
    @(negedge clock);
    reset_n   = 1'b1;
  endtask

  task automatic start_frames(input int n);
    frames_left = n;
    done        = 0;
    enable      = 1'b1;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  int base;

  initial begin : seq
    reset_n = 1'b0;
    enable  = 1'b0;
    repeat (2) @(negedge clock);
    check_val("rst_s_ready", s_ready, 0);
    check_val("rst_pix", pix_out, 0);
    check_val("rst_control", control, 0);
    check_val("rst_sof_eol", {sof, eol}, 0);
    check_val("rst_uf_busy", {underflow, busy}, 0);
    reset_n = 1'b1;
    #1;
    check_val("post_rst_s_ready", s_ready, 1);

    // Two back-to-back frames from a continuous source.
    src_total += 16;
    start_frames(2);
    wait_for(2, 1, "t2_frame2_start");
    enable = 1'b0;
    wait_for(1, 0, "t2_done");
    check_val("t2_all_consumed", exp_q.size(), 0);
    wait_for(3, 0, "t2_busy_fall");

    // Source delivers only 5 pixels: last 3 go out as zeros with underflow.
    do_reset();
    src_total += 5;
    start_frames(1);
    wait_for(0, 0, "t3_start");
    enable = 1'b0;
    wait_for(1, 0, "t3_done");
    check_val("t3_uf_sticky", underflow, 1);
    wait_for(3, 0, "t3_busy_fall");
    check_val("t3_uf_held", underflow, 1);

    // Idle with enable low: FIFO fills to 4, nothing toggles.
    do_reset();
    quiet      = 1;
    quiet_viol = 0;
    base       = n_acc;
    src_total += 6;
    repeat (12) @(negedge clock);
    check_val("t4_s_ready_full", s_ready, 0);
    check_val("t4_accepts", n_acc - base, 4);
    check_val("t4_quiet", quiet_viol, 0);
    quiet = 0;

    // Enable dropped at pixel 3: frame completes, no second frame.
    sof_stray  = 0;
    src_total += 2;
    start_frames(1);
    wait_for(0, 2, "t5_px3");
    enable = 1'b0;
    wait_for(1, 0, "t5_done");
    wait_for(3, 0, "t5_busy_fall");
    check_val("t5_busy_low", busy, 0);
    repeat (30) @(negedge clock);
    check_val("t5_no_second_sof", sof_stray, 0);
    check_val("t5_all_consumed", exp_q.size(), 0);
    check_val("t5_uf", underflow, 0);

    // Reset for one cycle mid-line, then restart from a refilled FIFO.
    do_reset();
    src_total += 20;
    start_frames(1);
    wait_for(0, 2, "t6_px2");
    reset_n   = 1'b0;
    abort_req = 1;
    @(negedge clock);
    check_val("t6_pix", pix_out, 0);
    check_val("t6_ctrl_sof_eol", {control, sof, eol}, 0);
    check_val("t6_uf_busy", {underflow, busy}, 0);
    reset_n = 1'b1;
    #1;
    check_val("t6_s_ready", s_ready, 1);
    wait_for(0, 0, "t6_restart");
    enable = 1'b0;
    wait_for(1, 0, "t6_done");

`ifdef TEST_PATTERN_EN
    src_total = n_src;
    do_reset();
    pattern_sel = 1'b1;
    pat_mode    = 1;
    start_frames(1);
    wait_for(0, 0, "t7_start");
    enable = 1'b0;
    wait_for(1, 0, "t7_done");
    check_val("t7_uf", underflow, 0);
    pat_mode = 0;
`endif

    repeat (3) @(negedge clock);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
